// File: rtl/ldl_sfifo_rd_stream_if.sv
// Read-port and output-stream bundle for ldl_sfifo_rd_stream.
// master = the reader block, slave = the FIFO plus downstream consumer side.
interface ldl_sfifo_rd_stream_if #(
   parameter int unsigned DW = 8
);
   logic          fifo_empty;
   logic [DW-1:0] fifo_dout;
   logic          fifo_re;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [1:0]    level;

   modport master (
      input  fifo_empty, fifo_dout, m_ready,
      output fifo_re, m_valid, m_data, level
   );

   modport slave (
      output fifo_empty, fifo_dout, m_ready,
      input  fifo_re, m_valid, m_data, level
   );
endinterface

// File: rtl/ldl_sfifo_rd_stream.sv
// Read-side consumer for LDL_sfifo_v1: pops the FIFO into a 2-entry register buffer
// and presents the buffered words as a valid/ready stream.
module ldl_sfifo_rd_stream #(
   parameter int unsigned DW    = 8,
   parameter int unsigned AHEAD = 1
) (
   input logic                   clk,
   input logic                   rst,
   ldl_sfifo_rd_stream_if.master bus
);

   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] tail_q, tail_d;
   logic [1:0]    level_q, level_d;
   logic [1:0]    slot;
   logic [2:0]    occ;
   logic          inflight;
   logic          pop;
   logic          wr;

   assign pop = (level_q != 2'd0) & bus.m_ready;

   // Count the word in flight as occupied so a late AHEAD=0 capture always has room.
   assign occ         = {1'b0, level_q} + {2'b00, inflight} - {2'b00, pop};
   assign bus.fifo_re = rst & ~bus.fifo_empty & (occ < 3'd2);

   generate
      if (AHEAD != 0) begin : g_ahead
         assign inflight = 1'b0;
         assign wr       = bus.fifo_re;
      end else begin : g_registered
         logic inflight_q;

         always_ff @(posedge clk) begin
            if (!rst) begin
               inflight_q <= 1'b0;
            end else begin
               inflight_q <= bus.fifo_re;
            end
         end

         assign inflight = inflight_q;
         assign wr       = inflight_q;
      end
   endgenerate

   // Write slot is computed after the pop shift so order survives a simultaneous pop.
   assign slot = level_q - {1'b0, pop};

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q + {1'b0, wr} - {1'b0, pop};
      if (pop) begin
         head_d = tail_q;
      end
      if (wr) begin
         if (slot == 2'd0) begin
            head_d = bus.fifo_dout;
         end else begin
            tail_d = bus.fifo_dout;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
      end
   end

   assign bus.m_valid = (level_q != 2'd0);
   assign bus.m_data  = head_q;
   assign bus.level   = level_q;

endmodule

// File: tb/tb_ldl_sfifo_rd_stream.sv
// Bench: two readers (AHEAD=0 at index 0, AHEAD=1 at index 1) each on a behavioural FIFO,
// fed identical random traffic and checked against the written word order.
module tb_ldl_sfifo_rd_stream;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       m_ready = 1'b0;
   int         n_cmp = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   ldl_sfifo_rd_stream_if #(.DW(DW)) bus0 ();
   ldl_sfifo_rd_stream_if #(.DW(DW)) bus1 ();

   ldl_sfifo_rd_stream #(.DW(DW), .AHEAD(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   ldl_sfifo_rd_stream #(.DW(DW), .AHEAD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Behavioural FIFOs: [0] registered read data, [1] first-word fall-through.
   logic [7:0] fmem  [2][DEPTH];
   logic [4:0] fcnt  [2];
   logic [3:0] fwp   [2];
   logic [3:0] frp   [2];
   logic [7:0] fdreg [2];
   logic       re [2], fempty [2], ffull [2], mv [2];
   logic [7:0] md [2];
   logic [1:0] lvl [2];

   assign re[0] = bus0.fifo_re;  assign re[1] = bus1.fifo_re;
   assign mv[0] = bus0.m_valid;  assign mv[1] = bus1.m_valid;
   assign md[0] = bus0.m_data;   assign md[1] = bus1.m_data;
   assign lvl[0] = bus0.level;   assign lvl[1] = bus1.level;
   assign fempty[0] = (fcnt[0] == 5'd0);  assign fempty[1] = (fcnt[1] == 5'd0);
   assign ffull[0]  = (fcnt[0] == 5'd16); assign ffull[1]  = (fcnt[1] == 5'd16);
   assign bus0.fifo_empty = fempty[0];
   assign bus1.fifo_empty = fempty[1];
   assign bus0.fifo_dout  = fdreg[0];
   assign bus1.fifo_dout  = fmem[1][frp[1]];
   assign bus0.m_ready    = m_ready;
   assign bus1.m_ready    = m_ready;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            fcnt[k] <= 5'd0; fwp[k] <= 4'd0; frp[k] <= 4'd0; fdreg[k] <= 8'h00;
         end else begin
            if (wr_en && !ffull[k]) begin
               fmem[k][fwp[k]] <= wr_data;
               fwp[k] <= fwp[k] + 4'd1;
            end
            if (re[k] && !fempty[k]) begin
               fdreg[k] <= fmem[k][frp[k]];
               frp[k] <= frp[k] + 4'd1;
            end
            fcnt[k] <= fcnt[k] + 5'(wr_en && !ffull[k]) - 5'(re[k] && !fempty[k]);
         end
      end
   end

   // Monitor: collects accepted words, counts reads and protocol violations.
   logic [7:0] got0 [$];
   logic [7:0] got1 [$];
   int         re_cnt [2] = '{0, 0};
   int         viol [2] = '{0, 0};
   logic       held [2] = '{1'b0, 1'b0};
   logic [7:0] held_d [2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            if (mv[k] && m_ready) begin
               if (k == 0) got0.push_back(md[k]);
               else        got1.push_back(md[k]);
            end
            if (re[k]) re_cnt[k] <= re_cnt[k] + 1;
            if (lvl[k] == 2'd3 || (re[k] && fempty[k]) || (mv[k] !== (lvl[k] != 2'd0)) ||
                (held[k] && (!mv[k] || md[k] !== held_d[k])))
               viol[k] <= viol[k] + 1;
         end else if (re[k] !== 1'b0) begin
            viol[k] <= viol[k] + 1;
         end
         held[k]   <= rst && mv[k] && !m_ready;
         held_d[k] <= md[k];
      end
   end

   function automatic int got_size(int k);
      return (k == 0) ? got0.size() : got1.size();
   endfunction

   function automatic logic [7:0] got_word(int k, int i);
      return (k == 0) ? got0[i] : got1[i];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; wr_en = 1'b0; m_ready = 1'b0;
      step(); step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; wr_en = 1'b0; m_ready = 1'b1;
      step();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_cmp += 4;
         if (mv[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", k, mv[k]); end
         if (lvl[k] !== 2'd0) begin n_fail++; $display("FAIL reset_level[%0d]: got %0d want 0", k, lvl[k]); end
         if (md[k] !== 8'h00) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 00", k, md[k]); end
         if (re[k] !== 1'b0) begin n_fail++; $display("FAIL reset_re[%0d]: got %b want 0", k, re[k]); end
      end
      step();
      rst = 1'b1;
   endtask

   task automatic test_stream();
      logic [7:0] w [5];
      int base [2], rbase [2], vbase [2], t_e [2], t_v [2], t_last [2], nv [2];
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
      for (int k = 0; k < 2; k++) begin
         base[k] = got_size(k); rbase[k] = re_cnt[k]; vbase[k] = viol[k];
         t_e[k] = -1; t_v[k] = -1; t_last[k] = -1; nv[k] = 0;
      end
      for (int c = 0; c < 16; c++) begin
         wr_en = (c < 5);
         if (c < 5) wr_data = w[c];
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!fempty[k] && t_e[k] < 0) t_e[k] = c;
            if (mv[k]) begin
               if (t_v[k] < 0) t_v[k] = c;
               t_last[k] = c; nv[k]++;
            end
         end
         step();
      end
      wr_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_cmp += 6;
         if (t_v[k] - t_e[k] !== ((k == 1) ? 1 : 2)) begin
            n_fail++; $display("FAIL stream_latency[%0d]: got %0d want %0d", k, t_v[k] - t_e[k], (k == 1) ? 1 : 2);
         end
         if (nv[k] !== 5 || t_last[k] - t_v[k] !== 4) begin
            n_fail++; $display("FAIL stream_burst[%0d]: got %0d valid over %0d cycles want 5 over 5", k, nv[k], t_last[k] - t_v[k] + 1);
         end
         if (re_cnt[k] - rbase[k] !== 5) begin
            n_fail++; $display("FAIL stream_re_count[%0d]: got %0d want 5", k, re_cnt[k] - rbase[k]);
         end
         if (lvl[k] !== 2'd0) begin n_fail++; $display("FAIL stream_level_end[%0d]: got %0d want 0", k, lvl[k]); end
         if (got_size(k) - base[k] !== 5) begin
            n_fail++; $display("FAIL stream_count[%0d]: got %0d want 5", k, got_size(k) - base[k]);
         end else begin
            for (int i = 0; i < 5; i++)
               if (got_word(k, base[k] + i) !== w[i]) begin
                  n_fail++; $display("FAIL stream_order[%0d] word %0d: got %h want %h", k, i, got_word(k, base[k] + i), w[i]);
               end
         end
         if (viol[k] !== vbase[k]) begin n_fail++; $display("FAIL stream_protocol[%0d]: got %0d violations want 0", k, viol[k] - vbase[k]); end
      end
   endtask

   task automatic test_stall();
      logic [7:0] w [8];
      int base [2], rbase [2], vbase [2], bad [2];
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
      for (int k = 0; k < 2; k++) begin
         base[k] = got_size(k); rbase[k] = re_cnt[k]; vbase[k] = viol[k]; bad[k] = 0;
      end
      for (int c = 0; c < 18; c++) begin
         wr_en = (c < 8);
         if (c < 8) wr_data = w[c];
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            if (c >= 6 && (mv[k] !== 1'b1 || md[k] !== w[0])) bad[k]++;
         step();
      end
      wr_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_cmp += 3;
         if (bad[k] !== 0) begin n_fail++; $display("FAIL stall_hold[%0d]: got %0d unstable cycles want 0", k, bad[k]); end
         if (lvl[k] !== 2'd2) begin n_fail++; $display("FAIL stall_level[%0d]: got %0d want 2", k, lvl[k]); end
         if (re_cnt[k] - rbase[k] !== 2) begin
            n_fail++; $display("FAIL stall_re_count[%0d]: got %0d want 2", k, re_cnt[k] - rbase[k]);
         end
      end
      m_ready = 1'b1;
      repeat (30) step();
      for (int k = 0; k < 2; k++) begin
         n_cmp += 3;
         if (got_size(k) - base[k] !== 8) begin
            n_fail++; $display("FAIL stall_count[%0d]: got %0d want 8", k, got_size(k) - base[k]);
         end else begin
            for (int i = 0; i < 8; i++)
               if (got_word(k, base[k] + i) !== w[i]) begin
                  n_fail++; $display("FAIL stall_order[%0d] word %0d: got %h want %h", k, i, got_word(k, base[k] + i), w[i]);
               end
         end
         if (lvl[k] !== 2'd0) begin n_fail++; $display("FAIL stall_level_end[%0d]: got %0d want 0", k, lvl[k]); end
         if (viol[k] !== vbase[k]) begin n_fail++; $display("FAIL stall_protocol[%0d]: got %0d violations want 0", k, viol[k] - vbase[k]); end
      end
   endtask

   // Shared by the toggle and random scenarios: ready pattern 0 = alternate, 1 = random.
   task automatic run_traffic(input int mode, input int cycles, output logic [7:0] sent [$]);
      sent = {};
      for (int c = 0; c < cycles; c++) begin
         if (mode == 0) begin
            wr_en   = (c % 2 == 0) && (sent.size() < 10);
            m_ready = (c % 2 == 0);
         end else begin
            wr_en   = ($urandom_range(0, 1) == 1) && !ffull[0] && !ffull[1];
            m_ready = ($urandom_range(0, 3) != 0);
         end
         wr_data = 8'($urandom);
         if (wr_en) sent.push_back(wr_data);
         step();
      end
      wr_en = 1'b0;
      m_ready = 1'b1;
      repeat (40) step();
   endtask

   task automatic test_toggle();
      logic [7:0] sent [$];
      int base [2], vbase [2];
      do_reset();
      for (int k = 0; k < 2; k++) begin base[k] = got_size(k); vbase[k] = viol[k]; end
      run_traffic(0, 40, sent);
      for (int k = 0; k < 2; k++) begin
         n_cmp += 2;
         if (got_size(k) - base[k] !== sent.size()) begin
            n_fail++; $display("FAIL toggle_count[%0d]: got %0d want %0d", k, got_size(k) - base[k], sent.size());
         end else begin
            for (int i = 0; i < sent.size(); i++)
               if (got_word(k, base[k] + i) !== sent[i]) begin
                  n_fail++; $display("FAIL toggle_order[%0d] word %0d: got %h want %h", k, i, got_word(k, base[k] + i), sent[i]);
               end
         end
         if (viol[k] !== vbase[k]) begin n_fail++; $display("FAIL toggle_protocol[%0d]: got %0d violations want 0", k, viol[k] - vbase[k]); end
      end
   endtask

   task automatic test_random();
      logic [7:0] sent [$];
      int base [2], vbase [2];
      do_reset();
      for (int k = 0; k < 2; k++) begin base[k] = got_size(k); vbase[k] = viol[k]; end
      run_traffic(1, 120, sent);
      for (int k = 0; k < 2; k++) begin
         n_cmp += 2;
         if (got_size(k) - base[k] !== sent.size()) begin
            n_fail++; $display("FAIL random_count[%0d]: got %0d want %0d", k, got_size(k) - base[k], sent.size());
         end else begin
            for (int i = 0; i < sent.size(); i++)
               if (got_word(k, base[k] + i) !== sent[i]) begin
                  n_fail++; $display("FAIL random_order[%0d] word %0d: got %h want %h", k, i, got_word(k, base[k] + i), sent[i]);
               end
         end
         if (viol[k] !== vbase[k]) begin n_fail++; $display("FAIL random_protocol[%0d]: got %0d violations want 0", k, viol[k] - vbase[k]); end
      end
   endtask

   task automatic test_reset_mid();
      int base [2];
      do_reset();
      m_ready = 1'b0;
      for (int c = 0; c < 9; c++) begin
         wr_en = (c < 4);
         wr_data = 8'($urandom);
         step();
      end
      wr_en = 1'b0;
      m_ready = 1'b1;
      step();
      // One pop with a refill: AHEAD=0 now holds one word with one read in flight.
      m_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_cmp += 4;
      if (lvl[0] !== 2'd1) begin n_fail++; $display("FAIL mid_pre_level[0]: got %0d want 1", lvl[0]); end
      if (lvl[1] !== 2'd2) begin n_fail++; $display("FAIL mid_pre_level[1]: got %0d want 2", lvl[1]); end
      if (re[0] !== 1'b0 || re[1] !== 1'b0) begin
         n_fail++; $display("FAIL mid_re_in_reset: got %b%b want 00", re[0], re[1]);
      end
      if (u_dut0.g_registered.inflight_q !== 1'b1) begin
         n_fail++; $display("FAIL mid_inflight[0]: got %b want 1", u_dut0.g_registered.inflight_q);
      end
      step();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_cmp += 3;
         if (mv[k] !== 1'b0) begin n_fail++; $display("FAIL mid_valid[%0d]: got %b want 0", k, mv[k]); end
         if (lvl[k] !== 2'd0) begin n_fail++; $display("FAIL mid_level[%0d]: got %0d want 0", k, lvl[k]); end
         if (md[k] !== 8'h00) begin n_fail++; $display("FAIL mid_data[%0d]: got %h want 00", k, md[k]); end
      end
      step();
      rst = 1'b1;
      m_ready = 1'b1;
      for (int k = 0; k < 2; k++) base[k] = got_size(k);
      repeat (10) step();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (got_size(k) !== base[k]) begin
            n_fail++; $display("FAIL mid_discard[%0d]: got %0d words want 0", k, got_size(k) - base[k]);
         end
      end
   endtask

   task automatic test_full();
      logic [7:0] w [18];
      int base [2], vbase [2];
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 18; i++) w[i] = 8'($urandom);
      for (int k = 0; k < 2; k++) begin base[k] = got_size(k); vbase[k] = viol[k]; end
      for (int c = 0; c < 20; c++) begin
         wr_en = (c < 18);
         if (c < 18) wr_data = w[c];
         step();
      end
      wr_en = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_cmp += 3;
         if (ffull[k] !== 1'b1) begin n_fail++; $display("FAIL full_before[%0d]: got %b want 1", k, ffull[k]); end
         if (lvl[k] !== 2'd2) begin n_fail++; $display("FAIL full_level[%0d]: got %0d want 2", k, lvl[k]); end
         if (re[k] !== 1'b1) begin n_fail++; $display("FAIL full_first_re[%0d]: got %b want 1", k, re[k]); end
      end
      step();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (ffull[k] !== 1'b0) begin n_fail++; $display("FAIL full_after_pop[%0d]: got %b want 0", k, ffull[k]); end
      end
      repeat (30) step();
      for (int k = 0; k < 2; k++) begin
         n_cmp += 2;
         if (got_size(k) - base[k] !== 18) begin
            n_fail++; $display("FAIL full_count[%0d]: got %0d want 18", k, got_size(k) - base[k]);
         end else begin
            for (int i = 0; i < 18; i++)
               if (got_word(k, base[k] + i) !== w[i]) begin
                  n_fail++; $display("FAIL full_order[%0d] word %0d: got %h want %h", k, i, got_word(k, base[k] + i), w[i]);
               end
         end
         if (viol[k] !== vbase[k]) begin n_fail++; $display("FAIL full_protocol[%0d]: got %0d violations want 0", k, viol[k] - vbase[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_toggle();
      test_reset_mid();
      test_full();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
